// File: rtl/write_order_arbiter_pkg.sv
// rtl/write_order_arbiter_pkg.sv - shared state encoding and width helpers for the write order arbiter
package write_order_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } aw_state_e;

   localparam int DEF_M   = 2;
   localparam int DEF_NOT = 2;

   // Index width for n items, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/write_order_arbiter_if.sv
// rtl/write_order_arbiter_if.sv - per-slave AW/W scheduling signals between crossbar and arbiter
interface write_order_arbiter_if
   import write_order_arbiter_pkg::*;
#(
   parameter int M   = DEF_M,
   parameter int NOT = DEF_NOT
);
   localparam int SW = idx_w(M);
   localparam int OW = $clog2(NOT) + 1;

   logic [M-1:0]  AW_valid_f;
   logic          AW_ready_s;
   logic [M-1:0]  AW_grant_f;
   logic [SW-1:0] AW_sel;
   logic          AW_en;
   logic [M-1:0]  W_valid_f;
   logic [M-1:0]  W_last_f;
   logic          W_ready_s;
   logic [SW-1:0] W_sel;
   logic          W_en;
   logic [OW-1:0] outstanding;
   logic          full;
   logic          empty;

   // master: the arbiter, which drives the crossbar selectors
   modport master (
      input  AW_valid_f, AW_ready_s, W_valid_f, W_last_f, W_ready_s,
      output AW_grant_f, AW_sel, AW_en, W_sel, W_en, outstanding, full, empty
   );

   modport slave (
      output AW_valid_f, AW_ready_s, W_valid_f, W_last_f, W_ready_s,
      input  AW_grant_f, AW_sel, AW_en, W_sel, W_en, outstanding, full, empty
   );

endinterface

// File: rtl/write_order_arbiter_fifo.sv
// rtl/write_order_arbiter_fifo.sv - in-order queue of accepted AW master indices
module wr_order_fifo #(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit compare
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/write_order_arbiter.sv
// rtl/write_order_arbiter.sv - round-robin AW arbiter with in-order W steering for one slave port
module write_order_arbiter
   import write_order_arbiter_pkg::*;
#(
   parameter int M                     = DEF_M,
   parameter int NUM_OUTSTANDING_TRANS = DEF_NOT
) (
   input logic                   clk,
   input logic                   clr,
   write_order_arbiter_if.master bus
);
   localparam int SW = idx_w(M);
   localparam int OW = $clog2(NUM_OUTSTANDING_TRANS) + 1;

   aw_state_e     state_q, state_d;
   logic [SW-1:0] rr_q, rr_d;
   logic [SW-1:0] aw_sel_q, aw_sel_d;
   logic [M-1:0]  grant_q, grant_d;
   logic          aw_en_q, aw_en_d;
   logic [SW-1:0] winner;
   logic          found;
   logic          aw_hs, push, w_hs, pop;
   logic [SW-1:0] head;
   logic [OW-1:0] count;
   logic          fifo_full, fifo_empty;

   // Scan rr_q, rr_q+1, ... modulo M; first valid requester wins
   always_comb begin
      int            tmp;
      logic [SW-1:0] idx;
      winner = '0;
      found  = 1'b0;
      tmp    = 0;
      idx    = '0;
      for (int i = 0; i < M; i++) begin
         tmp = int'(rr_q) + i;
         if (tmp >= M) tmp = tmp - M;
         idx = SW'(tmp);
         if (!found && bus.AW_valid_f[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // A dropped AWVALID keeps the grant; only a real handshake releases it
   assign aw_hs = (state_q == GRANT) & bus.AW_valid_f[aw_sel_q] & bus.AW_ready_s;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      aw_sel_d = aw_sel_q;
      grant_d  = grant_q;
      aw_en_d  = aw_en_q;
      push     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found && !fifo_full) begin
               state_d  = GRANT;
               aw_sel_d = winner;
               grant_d  = M'(1) << winner;
               aw_en_d  = 1'b1;
            end
         end
         GRANT: begin
            if (aw_hs) begin
               push    = 1'b1;
               rr_d    = (aw_sel_q == SW'(M - 1)) ? '0 : aw_sel_q + 1'b1;
               state_d = IDLE;
               grant_d = '0;
               aw_en_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         aw_sel_q <= '0;
         grant_q  <= '0;
         aw_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         aw_sel_q <= aw_sel_d;
         grant_q  <= grant_d;
         aw_en_q  <= aw_en_d;
      end
   end

   assign w_hs = !fifo_empty & bus.W_valid_f[head] & bus.W_ready_s;
   assign pop  = w_hs & bus.W_last_f[head];

   wr_order_fifo #(
      .WIDTH (SW),
      .DEPTH (NUM_OUTSTANDING_TRANS)
   ) u_order_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (aw_sel_q),
      .head  (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.AW_grant_f  = grant_q;
   assign bus.AW_sel      = aw_sel_q;
   assign bus.AW_en       = aw_en_q;
   assign bus.W_sel       = head;
   assign bus.W_en        = !fifo_empty;
   assign bus.outstanding = count;
   assign bus.full        = fifo_full;
   assign bus.empty       = fifo_empty;

endmodule
